// File: rtl/serial_bus_master.sv
// serial_bus_master: arbitrates two requesters onto one serial frame engine
// that talks to up to four single-wire slave links (addr[13:12] selects one).
module serial_bus_master #(
  parameter int NSLV        = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  m_req,
  input  logic [1:0]  m_we,
  input  logic [27:0] m_addr,
  input  logic [15:0] m_wdata,
  output logic [1:0]  m_gnt,
  output logic [1:0]  m_done,
  output logic [1:0]  m_err,
  output logic [7:0]  m_rdata,
  output logic [3:0]  s_tx,
  input  logic [3:0]  s_rx,
  output logic        busy
);

  // Counter must hold the ack timeout and the 12 address bit positions.
  localparam int CW = ($clog2(ACK_TIMEOUT) > 4) ? $clog2(ACK_TIMEOUT) : 4;

  typedef enum logic [2:0] {
    IDLE, REQ, GAP, ADDR, RW, WDATA, RDATA, RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [1:0]    sel_q, sel_d;
  logic [11:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          tx_bit_q, tx_bit_d;

  logic          win;
  logic [13:0]   req_addr;
  logic          req_we;
  logic [7:0]    req_wdata;
  logic          rx_bit;
  logic          sel_valid;

  // Round-robin winner: the pointed-to requester first, else the other one.
  assign win       = m_req[ptr_q] ? ptr_q : ~ptr_q;
  assign req_addr  = win ? m_addr[27:14]  : m_addr[13:0];
  assign req_we    = win ? m_we[1]        : m_we[0];
  assign req_wdata = win ? m_wdata[15:8]  : m_wdata[7:0];
  assign rx_bit    = s_rx[sel_q];
  assign sel_valid = int'(sel_q) < NSLV;

  // Next-state, datapath and output pulse logic for the frame engine.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_d     = ((|done_q) || (|err_q)) ? 2'b00 : gnt_q;
    done_d    = 2'b00;
    err_d     = 2'b00;
    sel_d     = sel_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    shift_d   = shift_q;
    rdata_d   = rdata_q;
    tx_bit_d  = tx_bit_q;
    case (state_q)
      IDLE: begin
        tx_bit_d = 1'b1;
        if (|m_req) begin
          gnt_d    = win ? 2'b10 : 2'b01;
          ptr_d    = ~win;
          sel_d    = req_addr[13:12];
          addr_d   = req_addr[11:0];
          we_d     = req_we;
          wdata_d  = req_wdata;
          cnt_d    = '0;
          state_d  = REQ;
          // An unpopulated link never sees its line pulled low.
          tx_bit_d = !(int'(req_addr[13:12]) < NSLV);
        end
      end
      REQ: begin
        if (!sel_valid) begin
          err_d   = gnt_q;
          state_d = IDLE;
        end else if (!rx_bit) begin
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          tx_bit_d = 1'b1;
          err_d    = gnt_q;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = ADDR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ADDR: begin
        tx_bit_d = addr_q[cnt_q[3:0]];
        if (cnt_q == CW'(11)) begin
          cnt_d   = '0;
          state_d = RW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RW: begin
        tx_bit_d = we_q;
        cnt_d    = '0;
        state_d  = we_q ? WDATA : RDATA;
      end
      WDATA: begin
        if (cnt_q == CW'(8)) begin
          tx_bit_d = 1'b1;
          done_d   = gnt_q;
          cnt_d    = '0;
          state_d  = RECOVER;
        end else begin
          tx_bit_d = wdata_q[cnt_q[2:0]];
          cnt_d    = cnt_q + 1'b1;
        end
      end
      RDATA: begin
        // Two turnaround edges, then eight LSB-first samples.
        tx_bit_d = 1'b1;
        if (cnt_q == CW'(10)) begin
          rdata_d = shift_q;
          done_d  = gnt_q;
          cnt_d   = '0;
          state_d = RECOVER;
        end else begin
          if (cnt_q >= CW'(2)) begin
            shift_d = {rx_bit, shift_q[7:1]};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECOVER: begin
        // One settling edge, then wait for the slave to release its line.
        tx_bit_d = 1'b1;
        if (cnt_q == '0) begin
          cnt_d = CW'(1);
        end else if (rx_bit) begin
          state_d = IDLE;
        end
      end
      default: begin
        tx_bit_d = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      sel_q    <= 2'b00;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      shift_q  <= '0;
      rdata_q  <= '0;
      tx_bit_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
      tx_bit_q <= tx_bit_d;
    end
  end

  // Only the selected link ever carries a 0; every other line idles high.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_tx
      assign s_tx[gi] = ~((sel_q == 2'(gi)) & ~tx_bit_q);
    end
  endgenerate

  assign m_gnt   = gnt_q;
  assign m_done  = done_q;
  assign m_err   = err_q;
  assign m_rdata = rdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_serial_bus_master.sv
// Directed testbench for serial_bus_master with an inline slave model.
module tb_serial_bus_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  m_req;
  logic [1:0]  m_we;
  logic [27:0] m_addr;
  logic [15:0] m_wdata;
  logic [1:0]  m_gnt;
  logic [1:0]  m_done;
  logic [1:0]  m_err;
  logic [7:0]  m_rdata;
  logic [3:0]  s_tx;
  logic [3:0]  s_rx;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  serial_bus_master #(.NSLV(2), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_done(m_done), .m_err(m_err),
    .m_rdata(m_rdata), .s_tx(s_tx), .s_rx(s_rx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure grant-to-grant spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a grant; returns on the negedge after the grant edge.
  task automatic wait_grant(input string tag, input logic [1:0] exp_gnt);
    int n;
    n = 0;
    @(negedge clk);
    while (m_gnt == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant"}, 32'(m_gnt), 32'(exp_gnt));
  endtask

  // Run one acknowledged frame, acting as the selected slave.
  task automatic do_frame(input string tag, input logic [1:0] exp_gnt,
                          input logic [1:0] sel, input logic we,
                          input logic [11:0] addr, input logic [7:0] wd,
                          input logic [7:0] rd, input bit drop_req,
                          output int g_cyc);
    int last_c, done_c, others_bad, gnt_bad, err_seen;
    logic [1:0]  done_val;
    logic [27:0] stream, exp_stream;
    wait_grant(tag, exp_gnt);
    g_cyc = cyc;
    if (drop_req) m_req = 2'b00;
    last_c = we ? 27 : 29;
    done_c = -1; done_val = 2'b00;
    others_bad = 0; gnt_bad = 0; err_seen = 0;
    stream = '0;
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 28) stream[5'(c)] = s_tx[sel];
      for (int s = 0; s < 4; s++)
        if (2'(s) != sel && s_tx[s] !== 1'b1) others_bad++;
      if (m_gnt !== exp_gnt) gnt_bad++;
      if (m_done != 2'b00 && done_c < 0) begin
        done_c = c;
        done_val = m_done;
      end
      if (m_err != 2'b00) err_seen++;
      if (c == 2) s_rx[sel] = 1'b0;
      if (c == 3) s_rx[sel] = 1'b1;
      if (!we && c >= 20 && c <= 27) s_rx[sel] = rd[3'(c - 20)];
      if (!we && c == 28) s_rx[sel] = 1'b1;
    end
    for (int c = 0; c < 28; c++) begin
      if (c <= 5)       exp_stream[5'(c)] = 1'b0;
      else if (c <= 17) exp_stream[5'(c)] = addr[4'(c - 6)];
      else if (c == 18) exp_stream[5'(c)] = we;
      else if (we && c <= 26) exp_stream[5'(c)] = wd[3'(c - 19)];
      else              exp_stream[5'(c)] = 1'b1;
    end
    chk({tag, "_stream"}, 32'(stream), 32'(exp_stream));
    chk({tag, "_others_idle"}, 32'(others_bad), 32'd0);
    chk({tag, "_gnt_held"}, 32'(gnt_bad), 32'd0);
    chk({tag, "_no_err"}, 32'(err_seen), 32'd0);
    chk({tag, "_done_cycle"}, 32'(done_c), 32'(last_c));
    chk({tag, "_done_who"}, 32'(done_val), 32'(exp_gnt));
    if (we) chk({tag, "_slave_wdata"}, 32'(stream[26:19]), 32'(wd));
    else    chk({tag, "_rdata"}, 32'(m_rdata), 32'(rd));
  endtask

  initial begin
    int g0, g1, g2;
    rstn = 1'b0; m_req = 2'b00; m_we = 2'b00; m_addr = '0; m_wdata = '0;
    s_rx = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_s_tx", 32'(s_tx), 32'hF);
    chk("rst_gnt", 32'(m_gnt), 32'd0);
    chk("rst_done", 32'(m_done), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_rdata", 32'(m_rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Write from requester 0 to slave 1; request dropped after grant.
    m_we = 2'b01; m_addr[13:0] = 14'h1005; m_wdata[7:0] = 8'hA5; m_req = 2'b01;
    do_frame("wr0", 2'b01, 2'd1, 1'b1, 12'h005, 8'hA5, 8'h00, 1'b1, g0);
    @(negedge clk);
    chk("wr0_gnt_drop", 32'(m_gnt), 32'd0);
    chk("wr0_recover_busy", 32'(busy), 32'd1);

    // Read from requester 1 on slave 1; slave returns 8'h1A.
    m_we = 2'b00; m_addr[27:14] = 14'h1003; m_req = 2'b10;
    do_frame("rd1", 2'b10, 2'd1, 1'b0, 12'h003, 8'h00, 8'h1A, 1'b1, g0);

    // Both requesters held: grants alternate 0,1,0 every 30 cycles.
    m_we = 2'b11; m_addr = {14'h1ABC, 14'h0123}; m_wdata = {8'hC3, 8'h3C};
    m_req = 2'b11;
    do_frame("arb_a", 2'b01, 2'd0, 1'b1, 12'h123, 8'h3C, 8'h00, 1'b0, g0);
    do_frame("arb_b", 2'b10, 2'd1, 1'b1, 12'hABC, 8'hC3, 8'h00, 1'b0, g1);
    chk("arb_spacing_1", 32'(g1 - g0), 32'd30);
    do_frame("arb_c", 2'b01, 2'd0, 1'b1, 12'h123, 8'h3C, 8'h00, 1'b1, g2);
    chk("arb_spacing_2", 32'(g2 - g1), 32'd30);
    chk("rdata_held", 32'(m_rdata), 32'h1A);

    // Slave 0 never acknowledges: abort after 16 REQ edges.
    repeat (4) @(negedge clk);
    m_we = 2'b00; m_addr[13:0] = 14'h0040; m_req = 2'b01;
    wait_grant("tmo", 2'b01);
    m_req = 2'b00;
    repeat (15) @(negedge clk);
    chk("tmo_no_err_yet", 32'({m_err, s_tx[0]}), 32'd0);
    @(negedge clk);
    chk("tmo_err", 32'(m_err), 32'd1);
    chk("tmo_s_tx", 32'(s_tx), 32'hF);
    chk("tmo_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("tmo_gnt_drop", 32'(m_gnt), 32'd0);

    // Invalid select 2'b11: error one cycle after grant, lines untouched.
    m_addr[13:0] = 14'h3010; m_req = 2'b01;
    wait_grant("inv", 2'b01);
    m_req = 2'b00;
    chk("inv_s_tx_g", 32'(s_tx), 32'hF);
    chk("inv_err_g", 32'(m_err), 32'd0);
    @(negedge clk);
    chk("inv_err", 32'(m_err), 32'd1);
    chk("inv_s_tx", 32'(s_tx), 32'hF);
    chk("inv_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("inv_gnt_drop", 32'(m_gnt), 32'd0);

    // Reset at A+10 of a write, then a clean read.
    m_we = 2'b01; m_addr[13:0] = 14'h1005; m_wdata[7:0] = 8'h5A; m_req = 2'b01;
    wait_grant("mid", 2'b01);
    m_req = 2'b00;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 2) s_rx[1] = 1'b0;
      if (c == 3) s_rx[1] = 1'b1;
      if (c == 12) rstn = 1'b0;
    end
    chk("mid_s_tx", 32'(s_tx), 32'hF);
    chk("mid_gnt", 32'(m_gnt), 32'd0);
    chk("mid_done_err", 32'({m_done, m_err}), 32'd0);
    chk("mid_rdata", 32'(m_rdata), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    s_rx = 4'hF;
    @(negedge clk);
    rstn = 1'b1;
    m_we = 2'b00; m_addr[27:14] = 14'h1077; m_req = 2'b10;
    do_frame("rd_post", 2'b10, 2'd1, 1'b0, 12'h077, 8'h00, 8'hC4, 1'b1, g0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
